sub_bytes_folded: RTL and testbench

- Parametrised, folded AES byte-substitution engine. Substitutes NBYTES bytes using NSBOX S-box lookups per cycle, iterating NBYTES/NSBOX passes.
- Supports forward and inverse S-box per transaction, with valid/ready handshakes on input and output.
- Sits between round-key/state registers and ShiftRows in area-reduced round datapaths. Generalises the fixed 4-byte, single-cycle word substitution.

---
 rtl/sub_bytes_folded.sv | 211 +++++++++++++++++++++
 tb/tb_sub_bytes_folded.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_folded.sv
// Folded AES SubBytes engine: NBYTES bytes substituted NSBOX at a time over
// NBYTES/NSBOX RUN cycles, forward or inverse S-box chosen per transaction.
module sub_bytes_folded #(
  parameter int NBYTES = 16,
  parameter int NSBOX  = 4,
  parameter int INV_EN = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] in_data,
  input  logic                in_inv,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] out_data,
  output logic                busy
);

  localparam int P  = NBYTES / NSBOX;
  localparam int CW = (P > 1) ? $clog2(P) : 1;
  localparam int LW = 8 * NSBOX;
  localparam logic [CW-1:0] LAST = CW'(P - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  generate
    if (NSBOX < 1 || NSBOX > NBYTES || (NBYTES % NSBOX) != 0) begin : g_param_check
      $fatal(1, "sub_bytes_folded: NSBOX must divide NBYTES");
    end
  endgenerate

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    logic [7:0] s;
    s = 8'h00;
    case (b)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    logic [7:0] s;
    s = 8'h00;
    case (b)
      8'h00: s = 8'h52; 8'h01: s = 8'h09; 8'h02: s = 8'h6a; 8'h03: s = 8'hd5; 8'h04: s = 8'h30; 8'h05: s = 8'h36; 8'h06: s = 8'ha5; 8'h07: s = 8'h38;
      8'h08: s = 8'hbf; 8'h09: s = 8'h40; 8'h0a: s = 8'ha3; 8'h0b: s = 8'h9e; 8'h0c: s = 8'h81; 8'h0d: s = 8'hf3; 8'h0e: s = 8'hd7; 8'h0f: s = 8'hfb;
      8'h10: s = 8'h7c; 8'h11: s = 8'he3; 8'h12: s = 8'h39; 8'h13: s = 8'h82; 8'h14: s = 8'h9b; 8'h15: s = 8'h2f; 8'h16: s = 8'hff; 8'h17: s = 8'h87;
      8'h18: s = 8'h34; 8'h19: s = 8'h8e; 8'h1a: s = 8'h43; 8'h1b: s = 8'h44; 8'h1c: s = 8'hc4; 8'h1d: s = 8'hde; 8'h1e: s = 8'he9; 8'h1f: s = 8'hcb;
      8'h20: s = 8'h54; 8'h21: s = 8'h7b; 8'h22: s = 8'h94; 8'h23: s = 8'h32; 8'h24: s = 8'ha6; 8'h25: s = 8'hc2; 8'h26: s = 8'h23; 8'h27: s = 8'h3d;
      8'h28: s = 8'hee; 8'h29: s = 8'h4c; 8'h2a: s = 8'h95; 8'h2b: s = 8'h0b; 8'h2c: s = 8'h42; 8'h2d: s = 8'hfa; 8'h2e: s = 8'hc3; 8'h2f: s = 8'h4e;
      8'h30: s = 8'h08; 8'h31: s = 8'h2e; 8'h32: s = 8'ha1; 8'h33: s = 8'h66; 8'h34: s = 8'h28; 8'h35: s = 8'hd9; 8'h36: s = 8'h24; 8'h37: s = 8'hb2;
      8'h38: s = 8'h76; 8'h39: s = 8'h5b; 8'h3a: s = 8'ha2; 8'h3b: s = 8'h49; 8'h3c: s = 8'h6d; 8'h3d: s = 8'h8b; 8'h3e: s = 8'hd1; 8'h3f: s = 8'h25;
      8'h40: s = 8'h72; 8'h41: s = 8'hf8; 8'h42: s = 8'hf6; 8'h43: s = 8'h64; 8'h44: s = 8'h86; 8'h45: s = 8'h68; 8'h46: s = 8'h98; 8'h47: s = 8'h16;
      8'h48: s = 8'hd4; 8'h49: s = 8'ha4; 8'h4a: s = 8'h5c; 8'h4b: s = 8'hcc; 8'h4c: s = 8'h5d; 8'h4d: s = 8'h65; 8'h4e: s = 8'hb6; 8'h4f: s = 8'h92;
      8'h50: s = 8'h6c; 8'h51: s = 8'h70; 8'h52: s = 8'h48; 8'h53: s = 8'h50; 8'h54: s = 8'hfd; 8'h55: s = 8'hed; 8'h56: s = 8'hb9; 8'h57: s = 8'hda;
      8'h58: s = 8'h5e; 8'h59: s = 8'h15; 8'h5a: s = 8'h46; 8'h5b: s = 8'h57; 8'h5c: s = 8'ha7; 8'h5d: s = 8'h8d; 8'h5e: s = 8'h9d; 8'h5f: s = 8'h84;
      8'h60: s = 8'h90; 8'h61: s = 8'hd8; 8'h62: s = 8'hab; 8'h63: s = 8'h00; 8'h64: s = 8'h8c; 8'h65: s = 8'hbc; 8'h66: s = 8'hd3; 8'h67: s = 8'h0a;
      8'h68: s = 8'hf7; 8'h69: s = 8'he4; 8'h6a: s = 8'h58; 8'h6b: s = 8'h05; 8'h6c: s = 8'hb8; 8'h6d: s = 8'hb3; 8'h6e: s = 8'h45; 8'h6f: s = 8'h06;
      8'h70: s = 8'hd0; 8'h71: s = 8'h2c; 8'h72: s = 8'h1e; 8'h73: s = 8'h8f; 8'h74: s = 8'hca; 8'h75: s = 8'h3f; 8'h76: s = 8'h0f; 8'h77: s = 8'h02;
      8'h78: s = 8'hc1; 8'h79: s = 8'haf; 8'h7a: s = 8'hbd; 8'h7b: s = 8'h03; 8'h7c: s = 8'h01; 8'h7d: s = 8'h13; 8'h7e: s = 8'h8a; 8'h7f: s = 8'h6b;
      8'h80: s = 8'h3a; 8'h81: s = 8'h91; 8'h82: s = 8'h11; 8'h83: s = 8'h41; 8'h84: s = 8'h4f; 8'h85: s = 8'h67; 8'h86: s = 8'hdc; 8'h87: s = 8'hea;
      8'h88: s = 8'h97; 8'h89: s = 8'hf2; 8'h8a: s = 8'hcf; 8'h8b: s = 8'hce; 8'h8c: s = 8'hf0; 8'h8d: s = 8'hb4; 8'h8e: s = 8'he6; 8'h8f: s = 8'h73;
      8'h90: s = 8'h96; 8'h91: s = 8'hac; 8'h92: s = 8'h74; 8'h93: s = 8'h22; 8'h94: s = 8'he7; 8'h95: s = 8'had; 8'h96: s = 8'h35; 8'h97: s = 8'h85;
      8'h98: s = 8'he2; 8'h99: s = 8'hf9; 8'h9a: s = 8'h37; 8'h9b: s = 8'he8; 8'h9c: s = 8'h1c; 8'h9d: s = 8'h75; 8'h9e: s = 8'hdf; 8'h9f: s = 8'h6e;
      8'ha0: s = 8'h47; 8'ha1: s = 8'hf1; 8'ha2: s = 8'h1a; 8'ha3: s = 8'h71; 8'ha4: s = 8'h1d; 8'ha5: s = 8'h29; 8'ha6: s = 8'hc5; 8'ha7: s = 8'h89;
      8'ha8: s = 8'h6f; 8'ha9: s = 8'hb7; 8'haa: s = 8'h62; 8'hab: s = 8'h0e; 8'hac: s = 8'haa; 8'had: s = 8'h18; 8'hae: s = 8'hbe; 8'haf: s = 8'h1b;
      8'hb0: s = 8'hfc; 8'hb1: s = 8'h56; 8'hb2: s = 8'h3e; 8'hb3: s = 8'h4b; 8'hb4: s = 8'hc6; 8'hb5: s = 8'hd2; 8'hb6: s = 8'h79; 8'hb7: s = 8'h20;
      8'hb8: s = 8'h9a; 8'hb9: s = 8'hdb; 8'hba: s = 8'hc0; 8'hbb: s = 8'hfe; 8'hbc: s = 8'h78; 8'hbd: s = 8'hcd; 8'hbe: s = 8'h5a; 8'hbf: s = 8'hf4;
      8'hc0: s = 8'h1f; 8'hc1: s = 8'hdd; 8'hc2: s = 8'ha8; 8'hc3: s = 8'h33; 8'hc4: s = 8'h88; 8'hc5: s = 8'h07; 8'hc6: s = 8'hc7; 8'hc7: s = 8'h31;
      8'hc8: s = 8'hb1; 8'hc9: s = 8'h12; 8'hca: s = 8'h10; 8'hcb: s = 8'h59; 8'hcc: s = 8'h27; 8'hcd: s = 8'h80; 8'hce: s = 8'hec; 8'hcf: s = 8'h5f;
      8'hd0: s = 8'h60; 8'hd1: s = 8'h51; 8'hd2: s = 8'h7f; 8'hd3: s = 8'ha9; 8'hd4: s = 8'h19; 8'hd5: s = 8'hb5; 8'hd6: s = 8'h4a; 8'hd7: s = 8'h0d;
      8'hd8: s = 8'h2d; 8'hd9: s = 8'he5; 8'hda: s = 8'h7a; 8'hdb: s = 8'h9f; 8'hdc: s = 8'h93; 8'hdd: s = 8'hc9; 8'hde: s = 8'h9c; 8'hdf: s = 8'hef;
      8'he0: s = 8'ha0; 8'he1: s = 8'he0; 8'he2: s = 8'h3b; 8'he3: s = 8'h4d; 8'he4: s = 8'hae; 8'he5: s = 8'h2a; 8'he6: s = 8'hf5; 8'he7: s = 8'hb0;
      8'he8: s = 8'hc8; 8'he9: s = 8'heb; 8'hea: s = 8'hbb; 8'heb: s = 8'h3c; 8'hec: s = 8'h83; 8'hed: s = 8'h53; 8'hee: s = 8'h99; 8'hef: s = 8'h61;
      8'hf0: s = 8'h17; 8'hf1: s = 8'h2b; 8'hf2: s = 8'h04; 8'hf3: s = 8'h7e; 8'hf4: s = 8'hba; 8'hf5: s = 8'h77; 8'hf6: s = 8'hd6; 8'hf7: s = 8'h26;
      8'hf8: s = 8'he1; 8'hf9: s = 8'h69; 8'hfa: s = 8'h14; 8'hfb: s = 8'h63; 8'hfc: s = 8'h55; 8'hfd: s = 8'h21; 8'hfe: s = 8'h0c; 8'hff: s = 8'h7d;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  state_t              state_r, state_s;
  logic [CW-1:0]       cnt_r, cnt_s;
  logic [8*NBYTES-1:0] data_r, data_s;
  logic [8*NBYTES-1:0] res_r, res_s;
  logic                inv_r, inv_s;
  logic [LW-1:0]       lane_in_s, lane_out_s;
  logic                in_ready_r, out_valid_r, busy_r;
  logic                accept_s, last_s;

  assign accept_s = in_valid && in_ready_r;
  assign last_s   = (cnt_r == LAST);

  // Next-state logic for the IDLE/RUN/DONE sequencer
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) state_s = RUN;  else state_s = IDLE;
      RUN:     if (last_s) state_s = DONE;   else state_s = RUN;
      DONE:    if (out_valid_r && out_ready) state_s = IDLE; else state_s = DONE;
      default: state_s = IDLE;
    endcase
  end

  // Pick the NSBOX captured bytes belonging to the current pass
  always_comb begin
    lane_in_s = '0;
    for (int p = 0; p < P; p++) begin
      lane_in_s = lane_in_s | ((cnt_r == CW'(p)) ? data_r[LW*p +: LW] : '0);
    end
  end

  // Per-lane S-box lookup; inverse path only reachable when INV_EN is set
  always_comb begin
    lane_out_s = '0;
    for (int l = 0; l < NSBOX; l++) begin
      if (INV_EN != 0 && inv_r) lane_out_s[8*l +: 8] = sbox_inv(lane_in_s[8*l +: 8]);
      else                      lane_out_s[8*l +: 8] = sbox_fwd(lane_in_s[8*l +: 8]);
    end
  end

  // Capture, pass counter and result-lane update
  always_comb begin
    data_s = data_r;
    inv_s  = inv_r;
    cnt_s  = cnt_r;
    res_s  = res_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          data_s = in_data;
          inv_s  = (INV_EN != 0) ? in_inv : 1'b0;
          cnt_s  = '0;
        end else begin
          cnt_s  = cnt_r;
        end
      end
      RUN: begin
        for (int p = 0; p < P; p++) begin
          if (cnt_r == CW'(p)) res_s[LW*p +: LW] = lane_out_s;
          else                 res_s[LW*p +: LW] = res_r[LW*p +: LW];
        end
        cnt_s = last_s ? '0 : cnt_r + CW'(1);
      end
      DONE:    cnt_s = cnt_r;
      default: cnt_s = '0;
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      data_r      <= '0;
      inv_r       <= 1'b0;
      res_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      data_r      <= data_s;
      inv_r       <= inv_s;
      res_r       <= res_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
      busy_r      <= (state_s != IDLE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = res_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_sub_bytes_folded.sv
// Scoreboard bench for sub_bytes_folded: three instances (16/4 with inverse,
// 4/4 with inverse, 4/1 forward-only) checked against a GF(2^8)-derived S-box.
module tb_sub_bytes_folded;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready, a_busy;
  logic [127:0] a_in_data, a_out_data;
  logic         b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready, b_busy;
  logic [31:0]  b_in_data, b_out_data;
  logic         c_in_valid, c_in_ready, c_in_inv, c_out_valid, c_out_ready, c_busy;
  logic [31:0]  c_in_data, c_out_data;

  sub_bytes_folded #(.NBYTES(16), .NSBOX(4), .INV_EN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_inv(a_in_inv), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .busy(a_busy));

  sub_bytes_folded #(.NBYTES(4), .NSBOX(4), .INV_EN(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_inv(b_in_inv), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .busy(b_busy));

  sub_bytes_folded #(.NBYTES(4), .NSBOX(1), .INV_EN(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_inv(c_in_inv), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_data(c_out_data), .busy(c_busy));

  logic [7:0]   fwd_tab [256];
  logic [7:0]   inv_tab [256];
  logic [127:0] sb_a[$], sb_b[$], sb_c[$];
  int           n_pass = 0;
  int           n_total = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // Reference S-box from field inverse plus affine map
  initial begin
    logic [7:0] iv, s;
    for (int x = 0; x < 256; x++) begin
      iv = 8'h00;
      for (int k = 1; k < 256; k++) if (gmul(8'(x), 8'(k)) == 8'h01) iv = 8'(k);
      s = iv ^ {iv[6:0], iv[7]} ^ {iv[5:0], iv[7:6]} ^ {iv[4:0], iv[7:5]} ^ {iv[3:0], iv[7:4]} ^ 8'h63;
      fwd_tab[x] = s;
      inv_tab[s] = 8'(x);
    end
  end

  function automatic logic [127:0] sub_model(input logic [127:0] d, input int nb, input logic inv);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < nb; i++) r[8*i +: 8] = inv ? inv_tab[d[8*i +: 8]] : fwd_tab[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic rdy(input int sel);
    case (sel)
      0: return a_in_ready;
      1: return b_in_ready;
      default: return c_in_ready;
    endcase
  endfunction

  function automatic logic vld(input int sel);
    case (sel)
      0: return a_out_valid;
      1: return b_out_valid;
      default: return c_out_valid;
    endcase
  endfunction

  task automatic drive(input int sel, input logic v, input logic [127:0] d, input logic inv);
    case (sel)
      0: begin a_in_valid = v; a_in_data = d;        a_in_inv = inv; end
      1: begin b_in_valid = v; b_in_data = d[31:0];  b_in_inv = inv; end
      default: begin c_in_valid = v; c_in_data = d[31:0]; c_in_inv = inv; end
    endcase
  endtask

  // Offer one transaction, push its expectation on acceptance, optionally time out_valid
  task automatic send(input int sel, input logic [127:0] d, input logic inv,
                      input logic [127:0] exp, input int lat_exp);
    logic acc, r;
    int n, lat;
    logic [31:0] junk;
    acc = 1'b0; n = 0;
    @(posedge clk); #1;
    drive(sel, 1'b1, d, inv);
    while (!acc && n < 40) begin
      @(negedge clk); r = rdy(sel);
      @(posedge clk); acc = r; n++;
    end
    if (!acc) check($sformatf("accept_timeout_%0d", sel), 128'd0, 128'd1);
    else begin
      case (sel)
        0: sb_a.push_back(exp);
        1: sb_b.push_back(exp);
        default: sb_c.push_back(exp);
      endcase
    end
    #1;
    junk = $urandom;
    drive(sel, 1'b0, {$urandom, $urandom, $urandom, $urandom}, junk[0]);
    if (acc && lat_exp > 0) begin
      lat = 0;
      do begin @(negedge clk); lat++; end while (!vld(sel) && lat < 40);
      check($sformatf("latency_%0d", sel), 128'(lat), 128'(lat_exp));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_a.size() + sb_b.size() + sb_c.size()) != 0 && n < 100) begin
      @(negedge clk); n++;
    end
    check("drain", 128'(sb_a.size() + sb_b.size() + sb_c.size()), 128'd0);
  endtask

  // Output monitor: compare each handshaken result against the scoreboard
  always @(negedge clk) begin
    if (rst_n && a_out_valid && a_out_ready) begin
      if (sb_a.size() == 0) check("a_spurious", 128'd1, 128'd0);
      else check("a_data", a_out_data, sb_a.pop_front());
    end
    if (rst_n && b_out_valid && b_out_ready) begin
      if (sb_b.size() == 0) check("b_spurious", 128'd1, 128'd0);
      else check("b_data", {96'd0, b_out_data}, sb_b.pop_front());
    end
    if (rst_n && c_out_valid && c_out_ready) begin
      if (sb_c.size() == 0) check("c_spurious", 128'd1, 128'd0);
      else check("c_data", {96'd0, c_out_data}, sb_c.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d, e;
    logic [31:0]  r32;
    rst_n = 1'b0;
    drive(0, 1'b0, 128'd0, 1'b0);
    drive(1, 1'b0, 128'd0, 1'b0);
    drive(2, 1'b0, 128'd0, 1'b0);
    a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_in_ready", 128'(a_in_ready), 128'd1);
    check("rst_a_out_valid", 128'(a_out_valid), 128'd0);
    check("rst_a_busy", 128'(a_busy), 128'd0);
    check("rst_a_out_data", a_out_data, 128'd0);
    check("rst_c_out_valid", 128'(c_out_valid), 128'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_hold_ready", 128'(a_in_ready), 128'd1);
    check("idle_hold_busy", 128'(a_busy), 128'd0);

    send(0, 128'h00112233445566778899aabbccddeeff, 1'b0, 128'h638293c31bfc33f5c4eeacea4bc12816, 5);
    send(0, 128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1, 128'h00112233445566778899aabbccddeeff, 5);
    send(1, 128'h005301ff, 1'b0, 128'h63ed7c16, 2);
    send(1, 128'h63ed7c16, 1'b1, 128'h005301ff, 2);
    send(2, 128'h005301ff, 1'b0, 128'h63ed7c16, 5);
    send(2, 128'h63636363, 1'b1, 128'hfbfbfbfb, 5);

    // Every byte value through both tables
    for (int t = 0; t < 16; t++) begin
      for (int k = 0; k < 16; k++) d[8*k +: 8] = 8'(16*t + k);
      send(0, d, 1'b0, sub_model(d, 16, 1'b0), 5);
      send(0, d, 1'b1, sub_model(d, 16, 1'b1), 5);
    end
    for (int t = 0; t < 4; t++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      r32 = $urandom;
      send(0, d, r32[0], sub_model(d, 16, r32[0]), 5);
    end
    drain();

    // Backpressure with a competing in_valid during DONE
    a_out_ready = 1'b0;
    d = {$urandom, $urandom, $urandom, $urandom};
    e = sub_model(d, 16, 1'b0);
    send(0, d, 1'b0, e, 5);
    drive(0, 1'b1, ~d, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", 128'(a_out_valid), 128'd1);
      check("bp_data", a_out_data, e);
      check("bp_in_ready", 128'(a_in_ready), 128'd0);
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    @(negedge clk);
    check("bp_release_ready", 128'(a_in_ready), 128'd1);
    check("bp_release_valid", 128'(a_out_valid), 128'd0);
    check("bp_release_busy", 128'(a_busy), 128'd0);
    a_out_ready = 1'b1;
    drain();

    // Reset while in pass 1
    d = {$urandom, $urandom, $urandom, $urandom};
    send(0, d, 1'b0, sub_model(d, 16, 1'b0), 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 128'(a_out_valid), 128'd0);
    check("midrst_ready", 128'(a_in_ready), 128'd1);
    check("midrst_busy", 128'(a_busy), 128'd0);
    check("midrst_data", a_out_data, 128'd0);
    sb_a.delete();
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("midrst_no_pulse", 128'(a_out_valid), 128'd0);
    end
    send(0, 128'd0, 1'b0, {16{8'h63}}, 5);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
